// File: rtl/m2m_seq_core.sv
// Multicycle memory-to-memory sequencer: three-word instructions, req/ack memory port, result to mem[A].
// Optional retired-instruction counter enabled by defining M2M_SEQ_RETIRE_CNT_EN.
module m2m_seq_core #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        op,
    output logic              busy,
    output logic              halted,
`ifdef M2M_SEQ_RETIRE_CNT_EN
    output logic [31:0]       retire_cnt,
`endif
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_OP = 3'd1,
        FETCH_A  = 3'd2,
        FETCH_B  = 3'd3,
        READ_A   = 3'd4,
        READ_B   = 3'd5,
        EXEC     = 3'd6,
        WRITE    = 3'd7
    } state_t;

    localparam logic [3:0]        OP_ADD  = 4'd0;
    localparam logic [3:0]        OP_SUB  = 4'd1;
    localparam logic [3:0]        OP_AND  = 4'd2;
    localparam logic [3:0]        OP_OR   = 4'd3;
    localparam logic [3:0]        OP_XOR  = 4'd4;
    localparam logic [3:0]        OP_MOV  = 4'd5;
    localparam logic [3:0]        OP_BEQZ = 4'd6;
    localparam logic [3:0]        OP_HALT = 4'd7;
    localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addrA;
    logic [ADDR_W-1:0] addrB;
    logic [DATA_W-1:0] aReg;
    logic [DATA_W-1:0] bReg;
    logic [DATA_W-1:0] destReg;
    logic [DATA_W-1:0] aluResult;
    logic [ADDR_W-1:0] pcNext;
    logic [3:0]        fetchedOp;
    logic              aIsZero;

    assign pcNext    = pc + PC_ONE;
    assign fetchedOp = mem_rdata[3:0];
    assign aIsZero   = (aReg == {DATA_W{1'b0}});

    // ALU result from the latched opcode and operands; BEQZ and illegal codes yield zero.
    always_comb begin
        aluResult = {DATA_W{1'b0}};
        case (op)
            OP_ADD:  aluResult = aReg + bReg;
            OP_SUB:  aluResult = aReg - bReg;
            OP_AND:  aluResult = aReg & bReg;
            OP_OR:   aluResult = aReg | bReg;
            OP_XOR:  aluResult = aReg ^ bReg;
            OP_MOV:  aluResult = bReg;
            default: aluResult = {DATA_W{1'b0}};
        endcase
    end

    // Sequencer FSM; every memory-port output is set on the edge that enters its state.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= PC_INIT;
            op        <= 4'd0;
            addrA     <= {ADDR_W{1'b0}};
            addrB     <= {ADDR_W{1'b0}};
            aReg      <= {DATA_W{1'b0}};
            bReg      <= {DATA_W{1'b0}};
            destReg   <= {DATA_W{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
`ifdef M2M_SEQ_RETIRE_CNT_EN
            retire_cnt <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && !err) begin
                        state    <= FETCH_OP;
                        halted   <= 1'b0;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                FETCH_OP: begin
                    if (mem_ack) begin
                        op <= fetchedOp;
                        pc <= pcNext;
                        if (fetchedOp == OP_HALT) begin
                            state   <= IDLE;
                            halted  <= 1'b1;
                            busy    <= 1'b0;
                            mem_req <= 1'b0;
                        end else if (fetchedOp[3]) begin
                            state   <= IDLE;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            mem_req <= 1'b0;
                        end else begin
                            state    <= FETCH_A;
                            mem_addr <= pcNext;
                        end
                    end
                end
                FETCH_A: begin
                    if (mem_ack) begin
                        addrA    <= mem_rdata[ADDR_W-1:0];
                        pc       <= pcNext;
                        state    <= FETCH_B;
                        mem_addr <= pcNext;
                    end
                end
                FETCH_B: begin
                    if (mem_ack) begin
                        addrB    <= mem_rdata[ADDR_W-1:0];
                        pc       <= pcNext;
                        state    <= READ_A;
                        mem_addr <= addrA;
                    end
                end
                READ_A: begin
                    if (mem_ack) begin
                        aReg     <= mem_rdata;
                        state    <= READ_B;
                        mem_addr <= addrB;
                    end
                end
                READ_B: begin
                    if (mem_ack) begin
                        bReg    <= mem_rdata;
                        state   <= EXEC;
                        mem_req <= 1'b0;
                    end
                end
                EXEC: begin
                    destReg <= aluResult;
                    mem_req <= 1'b1;
                    if (op == OP_BEQZ) begin
                        state  <= FETCH_OP;
                        mem_we <= 1'b0;
                        if (aIsZero) begin
                            pc       <= addrB;
                            mem_addr <= addrB;
                        end else begin
                            mem_addr <= pc;
                        end
`ifdef M2M_SEQ_RETIRE_CNT_EN
                        retire_cnt <= retire_cnt + 32'd1;
`endif
                    end else begin
                        state     <= WRITE;
                        mem_we    <= 1'b1;
                        mem_addr  <= addrA;
                        mem_wdata <= aluResult;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state    <= FETCH_OP;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
`ifdef M2M_SEQ_RETIRE_CNT_EN
                        retire_cnt <= retire_cnt + 32'd1;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
